// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered ARM immediate extender with a one-entry skid buffer.
// Define IMM_EXT_ERRCNT_EN to add err_clr/err_count (saturating count of reserved ImmSrc accepts).
module imm_extend_pipe #(
  parameter int XLEN     = 32,
  parameter int BR_SHIFT = 2,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [23:0]     Instr,
  input  logic [2:0]      ImmSrc,
  input  logic            carry_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ExtImm,
  output logic            shift_carry,
  output logic            illegal
`ifdef IMM_EXT_ERRCNT_EN
  ,
  input  logic            err_clr,
  output logic [CNT_W-1:0] err_count
`endif
);
  typedef struct packed {
    logic            ill;
    logic            sc;
    logic [XLEN-1:0] imm;
  } ent_t;
  ent_t new_e, main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, acc, pop;
  logic [5:0] sh;
  logic [31:0] imm8, ror;
  logic [XLEN-1:0] br_x, i12_x;
  assign sh    = {1'b0, Instr[11:8], 1'b0};
  assign imm8  = {24'b0, Instr[7:0]};
  // a zero rotate makes the left shift 32, which clears that term
  assign ror   = (imm8 >> sh) | (imm8 << (6'd32 - sh));
  assign br_x  = XLEN'($signed({Instr, {BR_SHIFT{1'b0}}}));
  assign i12_x = XLEN'($signed(Instr[11:0]));
  always_comb begin
    new_e.ill = ImmSrc > 3'd4;
    new_e.sc  = (ImmSrc == 3'd3 && Instr[11:8] != 4'd0) ? ror[31] : carry_in;
    new_e.imm = ImmSrc == 3'd0 ? XLEN'(Instr[7:0]) :
                ImmSrc == 3'd1 ? XLEN'(Instr[11:0]) :
                ImmSrc == 3'd2 ? br_x :
                ImmSrc == 3'd3 ? XLEN'(ror) :
                ImmSrc == 3'd4 ? i12_x : '0;
  end
  assign in_ready = !skid_v_q;
  assign acc      = in_valid && in_ready;
  assign pop      = main_v_q && out_ready;
  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (!main_v_q || pop) begin
      main_v_d = skid_v_q || acc;
      main_d   = skid_v_q ? skid_q : acc ? new_e : main_q;
      skid_v_d = skid_v_q && acc;
      skid_d   = (skid_v_q && acc) ? new_e : skid_q;
    end else if (acc) begin
      skid_v_d = 1'b1;
      skid_d   = new_e;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end
  assign out_valid   = main_v_q;
  assign ExtImm      = main_q.imm;
  assign shift_carry = main_q.sc;
  assign illegal     = main_q.ill;
`ifdef IMM_EXT_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = err_clr ? '0 : (acc && new_e.ill && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign err_count = cnt_q;
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: random and directed stimulus, arithmetic reference model, queue scoreboard.
module tb_imm_extend_pipe;
  localparam int XLEN = 32, BR_SHIFT = 2, CNT_W = 2;
  typedef struct {
    logic [XLEN-1:0] imm;
    logic            sc;
    logic            ill;
  } exp_t;
  logic clk = 0, reset_n = 0, in_valid = 0, out_ready = 0, carry_in = 0;
  logic in_ready, out_valid, shift_carry, illegal;
  logic [23:0] Instr = '0;
  logic [2:0] ImmSrc = '0;
  logic [XLEN-1:0] ExtImm;
`ifdef IMM_EXT_ERRCNT_EN
  logic err_clr = 0;
  logic [CNT_W-1:0] err_count;
`endif
  int checks = 0, errors = 0, pops = 0, cyc = 0;
  exp_t sb[$];
  logic stall_q = 0;
  logic [XLEN-1:0] held_q = '0;

  imm_extend_pipe #(.XLEN(XLEN), .BR_SHIFT(BR_SHIFT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .Instr(Instr), .ImmSrc(ImmSrc), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .ExtImm(ExtImm), .shift_carry(shift_carry), .illegal(illegal)
`ifdef IMM_EXT_ERRCNT_EN
    , .err_clr(err_clr), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [23:0] ins, input logic [2:0] src, input logic cin);
    exp_t e;
    int iv, t, r;
    longint v;
    longint unsigned a, w;
    iv = int'(ins);
    e.sc = cin;
    e.ill = 1'b0;
    v = 0;
    if (src == 3'd0) v = longint'(iv % 256);
    else if (src == 3'd1) v = longint'(iv % 4096);
    else if (src == 3'd2) begin
      t = iv >= 2**23 ? iv - 2**24 : iv;
      v = longint'(t) * (longint'(1) << BR_SHIFT);
    end else if (src == 3'd3) begin
      a = longint'(iv % 256);
      r = 2 * ((iv / 256) % 16);
      w = r == 0 ? a : ((a >> r) | (a << (32 - r))) % (64'd1 << 32);
      if (r != 0) e.sc = ((w >> 31) & 1) != 0;
      v = longint'(w);
    end else if (src == 3'd4) begin
      t = iv % 4096;
      v = longint'(t >= 2048 ? t - 4096 : t);
    end else e.ill = 1'b1;
    e.imm = XLEN'(v);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard input: an accept happens at the next rising edge
  always @(negedge clk)
    if (!reset_n) sb.delete();
    else if (in_valid && in_ready) sb.push_back(model(Instr, ImmSrc, carry_in));

  // monitor: an output is consumed at the next rising edge
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) stall_q <= 1'b0;
    else begin
      if (stall_q) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_imm", 64'(ExtImm), 64'(held_q));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", ExtImm);
        end else begin
          e = sb.pop_front();
          check("sb_imm", 64'(ExtImm), 64'(e.imm));
          check("sb_carry", 64'(shift_carry), 64'(e.sc));
          check("sb_illegal", 64'(illegal), 64'(e.ill));
        end
        pops <= pops + 1;
      end
      stall_q <= out_valid && !out_ready;
      held_q <= ExtImm;
    end
  end

  // called and returns at posedge+1; leaves in_valid low
  task automatic push_one(input logic [23:0] ins, input logic [2:0] src, input logic cin);
    int n = 0;
    in_valid = 1'b1;
    Instr = ins;
    ImmSrc = src;
    carry_in = cin;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("latency_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    exp_t ea;
    int c0, p0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_imm", 64'(ExtImm), 64'd0);
    check("rst_carry", 64'(shift_carry), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    // directed vectors
    out_ready = 1'b1;
    push_one(24'h0004FF, 3'd3, 1'b0);
    check("rot_imm", 64'(ExtImm), 64'hFF000000);
    check("rot_carry", 64'(shift_carry), 64'd1);
    push_one(24'h0000FF, 3'd3, 1'b1);
    check("rot0_imm", 64'(ExtImm), 64'h000000FF);
    check("rot0_carry", 64'(shift_carry), 64'd1);
    push_one(24'hFFFFFE, 3'd2, 1'b0);
    check("br_imm", 64'(ExtImm), 64'(XLEN'(64'hFFFFFFFFFFFFFFF8)));
    check("br_carry", 64'(shift_carry), 64'd0);
    push_one(24'h000800, 3'd4, 1'b1);
    check("sx12_imm", 64'(ExtImm), 64'(XLEN'(64'hFFFFFFFFFFFFF800)));
    push_one(24'h123456, 3'd6, 1'b1);
    check("rsv_imm", 64'(ExtImm), 64'd0);
    check("rsv_illegal", 64'(illegal), 64'd1);
    drain();
    // back-pressure: A, B fill both entries, C is held off
    out_ready = 1'b0;
    ea = model(24'h000ABC, 3'd1, 1'b0);
    push_one(24'h000ABC, 3'd1, 1'b0);
    push_one(24'h0001F3, 3'd0, 1'b1);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    Instr = 24'h800001;
    ImmSrc = 3'd2;
    carry_in = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_held_off", 64'(in_ready), 64'd0);
      check("bp_head", 64'(ExtImm), 64'(ea.imm));
    end
    p0 = pops;
    out_ready = 1'b1;
    push_one(24'h800001, 3'd2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("bp_delivered", 64'(pops - p0), 64'd3);
    // streaming
    c0 = cyc;
    p0 = pops;
    for (int i = 0; i < 10; i++) push_one(24'($urandom), 3'($urandom_range(0, 4)), 1'($urandom));
    check("stream_cycles", 64'(cyc - c0), 64'd10);
    @(posedge clk);
    #1;
    check("stream_outputs", 64'(pops - p0), 64'd10);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom);
      Instr = 24'($urandom);
      ImmSrc = 3'($urandom);
      carry_in = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    // reset with both entries full
    out_ready = 1'b0;
    push_one(24'h00037F, 3'd3, 1'b1);
    push_one(24'h000FFF, 3'd4, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_imm", 64'(ExtImm), 64'd0);
    check("arst_illegal", 64'(illegal), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_valid_after", 64'(out_valid), 64'd0);
`ifdef IMM_EXT_ERRCNT_EN
    check("cnt_reset", 64'(err_count), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_one(24'($urandom), 3'($urandom_range(5, 7)), 1'($urandom));
    check("cnt_saturate", 64'(err_count), 64'd3);
    err_clr = 1'b1;
    push_one(24'h00AA55, 3'd7, 1'b0);
    err_clr = 1'b0;
    check("cnt_clear", 64'(err_count), 64'd0);
    check("cnt_clear_illegal", 64'(illegal), 64'd1);
`endif
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, parametrised immediate extender for the pipelined ARM datapath. It sits between decode and execute and accepts the 24-bit instruction immediate field with a 3-bit ImmSrc code. It produces an XLEN-wide extended immediate, plus the shifter carry-out for rotated data-processing immediates. A valid/ready handshake with a one-entry skid buffer lets execute stalls back-pressure decode without dropping instructions.

## Interface
- XLEN, 32: output width; legal values 32 or 64.
- BR_SHIFT, 2: left shift applied to branch offsets.
- CNT_W, 8: width of the illegal-encoding counter (present only with IMM_EXT_ERRCNT_EN).
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode presents an immediate.
- in_ready  out  1  block can accept; equals NOT skid_valid.
- Instr  in  24  instruction bits [23:0].
- ImmSrc  in  3  extension mode.
- carry_in  in  1  current CPSR C flag.
- out_valid  out  1  ExtImm/shift_carry valid.
- out_ready  in  1  execute consumes this cycle.
- ExtImm  out  XLEN  extended immediate.
- shift_carry  out  1  shifter carry-out for mode 011.
- illegal  out  1  output entry came from a reserved ImmSrc.
- err_clr  in  1  synchronous clear of err_count (macro only).
- err_count  out  CNT_W  saturating count of accepted illegal encodings (macro only).

## Operation
- ImmSrc modes (zero-extension and sign-extension are to XLEN):
  - 000: zero-extend Instr[7:0]; shift_carry = carry_in.
  - 001: zero-extend Instr[11:0]; shift_carry = carry_in.
  - 010: sign-extend {Instr[23:0], BR_SHIFT zeros}, then truncate to XLEN.
  - 011: zero-extend Instr[7:0] to 32 bits, rotate right by 2*Instr[11:8] within 32 bits, then zero-extend to XLEN. shift_carry is carry_in when Instr[11:8]==0; otherwise it is bit 31 of the rotated value.
  - 100: sign-extend Instr[11:0]; shift_carry = carry_in.
  - 101–111: ExtImm = 0, shift_carry = carry_in, illegal = 1.
- shift_carry is carry_in in every mode except 011. In mode 010 this means shift_carry = carry_in.
- illegal = 0 for all legal modes.
- Accept happens when in_valid && in_ready. The result is computed combinationally at accept and registered.
- Storage is a main output register plus one skid register.
  - When the main register is empty, or being consumed (out_valid && out_ready), the accepted entry loads the main register.
  - Otherwise the accepted entry loads the skid register.
  - When the main register is consumed and the skid register is full, the skid entry moves to main. If an input is also accepted in that cycle, it goes to skid.
- Entries leave in acceptance order. No entry is dropped or duplicated.

## Timing
- Reset (async, any time, including mid-transfer) clears both entries:
  - out_valid = 0, ExtImm = 0, shift_carry = 0, illegal = 0, skid empty, err_count = 0.
  - in_ready = 1 in the first cycle after reset_n deasserts.
- Latency is 1 cycle: an input accepted at edge N is on the outputs after edge N, with out_valid = 1.
- Throughput is 1 entry per cycle while out_ready = 1.
- Outputs are held stable while out_valid && !out_ready.
- in_ready falls in the cycle after the skid register fills. It rises in the cycle after skid drains.
- in_ready never depends combinationally on out_ready.

## Configuration
- IMM_EXT_ERRCNT_EN defined: the err_clr/err_count ports and counter exist.
  - The counter increments on each accept with ImmSrc ∈ {101,110,111}.
  - It saturates at 2^CNT_W−1.
  - err_clr has priority: if err_clr and an illegal accept happen in the same cycle, err_count becomes 0.
- IMM_EXT_ERRCNT_EN undefined: the ports and counter are absent. The illegal output remains.

## Test plan
- Mode 011, Instr[11:0]=0x4FF, carry_in=0 -> ExtImm=0xFF000000, shift_carry=1. Instr[11:0]=0x0FF, carry_in=1 -> ExtImm=0x000000FF, shift_carry=1.
- Mode 010, Instr=0xFFFFFE, XLEN=32 -> ExtImm=0xFFFFFFF8. Same with XLEN=64 -> 0xFFFFFFFFFFFFFFF8. Mode 100, Instr[11:0]=0x800 -> 0xFFFFF800.
- Back-pressure: accept A, B, C back-to-back with out_ready=0 -> in_ready drops after B. C is held off. Releasing out_ready delivers A, B, C in order, one per cycle, with no loss.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles -> 10 outputs, first one cycle after the first accept, in_ready constantly 1.
- Reset: assert reset_n=0 with both entries full -> out_valid=0 and ExtImm=0 immediately. in_ready=1 after release.
- Macro on, CNT_W=2: 5 illegal accepts -> err_count saturates at 3. err_clr together with an illegal accept -> err_count 0, illegal=1 on that entry.
